// File: rtl/arb_pkg.sv
// ============================================================================
//  Module   : arb_pkg
//  Brief    : Shared constants and state type for the FIFO-mode PCI arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  // Number of bus masters; the request queue is exactly this deep.
  localparam int N_DEV = 8;

  // Width of a master index.
  localparam int IDX_W = $clog2(N_DEV);

  // Default number of clocks a granted master has to start FRAME#.
  localparam int TIMEOUT_DEFAULT = 16;

  // Grant sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_e;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/idx_queue.sv
// ============================================================================
//  Module   : idx_queue
//  Brief    : Circular buffer of master indices with push, pop, head and count.
//             Pop on empty and push on full are silently ignored.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idx_queue
  import arb_pkg::*;
#(
  parameter int DEPTH = N_DEV,   // must be a power of two so pointers wrap
  parameter int WIDTH = IDX_W
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule : idx_queue

`default_nettype wire

// File: rtl/arbiter_req_fifo.sv
// ============================================================================
//  Module   : arbiter_req_fifo
//  Brief    : FIFO-order request queue and grant sequencer for the PCI arbiter.
//             Queues newly asserted requesters in arrival order and grants the
//             head until its transaction ends, it withdraws, or it times out.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arbiter_req_fifo
  import arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_DEV-1:0] req_n_i,
  input  logic             frame_n_i,
  input  logic             irdy_n_i,
  output logic [N_DEV-1:0] gnt_n_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic [IDX_W:0]   count_o
);

  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [N_DEV-1:0] req_s_q;
  logic [N_DEV-1:0] queued_q, queued_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [N_DEV-1:0] gnt_n_q, gnt_n_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;

  logic [N_DEV-1:0] new_req;
  logic             push;
  logic [IDX_W-1:0] push_idx;
  logic             pop;
  logic [IDX_W-1:0] head;
  logic             q_empty;

  // Requesters not yet queued (a retired owner still requesting shows up here again).
  assign new_req = req_s_q & ~queued_q;

  idx_queue #(
    .DEPTH (N_DEV),
    .WIDTH (IDX_W)
  ) u_queue (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push),
    .push_data_i (push_idx),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count_o),
    .empty_o     (q_empty)
  );

  // Pick the lowest-numbered new requester; the rest wait for later cycles.
  always_comb begin
    push     = 1'b0;
    push_idx = '0;
    for (int i = N_DEV - 1; i >= 0; i--) begin
      if (new_req[i]) begin
        push     = 1'b1;
        push_idx = IDX_W'(i);
      end
    end
  end

  // Grant sequencer: next state, pop decision and registered grant outputs.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    pop         = 1'b0;
    case (state_q)
      IDLE: begin
        if (!q_empty) begin
          if (req_s_q[head]) begin
            state_d     = GRANT;
            gnt_valid_d = 1'b1;
            gnt_idx_d   = head;
            tmo_d       = '0;
          end else begin
            // Head withdrew while waiting: drop it without granting.
            pop = 1'b1;
          end
        end
      end
      GRANT: begin
        if (!frame_n_i) begin
          state_d = BUSY;
        end else if (!req_s_q[head] || (tmo_q == TMO_LAST)) begin
          pop         = 1'b1;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      BUSY: begin
        if (frame_n_i && irdy_n_i) begin
          pop         = 1'b1;
          gnt_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
    gnt_n_d = gnt_valid_d ? ~(N_DEV'(1) << gnt_idx_d) : '1;
  end

  // Membership mask: set on push, cleared when the entry leaves the head.
  always_comb begin
    queued_d = queued_q;
    if (push) queued_d[push_idx] = 1'b1;
    if (pop)  queued_d[head]     = 1'b0;
  end

  // State, request sampling and output registers; reset drops the grant at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      req_s_q     <= '0;
      queued_q    <= '0;
      tmo_q       <= '0;
      gnt_n_q     <= '1;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_s_q     <= ~req_n_i;
      queued_q    <= queued_d;
      tmo_q       <= tmo_d;
      gnt_n_q     <= gnt_n_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

  assign gnt_n_o     = gnt_n_q;
  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;

endmodule : arbiter_req_fifo

`default_nettype wire

// File: tb/tb_arbiter_req_fifo.sv
// ============================================================================
//  Module   : tb_arbiter_req_fifo
//  Brief    : Self-checking bench for arbiter_req_fifo with a queue-based
//             reference model, directed scenarios and random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_arbiter_req_fifo;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_n;
  logic       frame_n;
  logic       irdy_n;
  logic [7:0] gnt_n;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [3:0] count;

  always #5 clk = ~clk;

  arbiter_req_fifo #(.TIMEOUT(TMO)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_n_i     (req_n),
    .frame_n_i   (frame_n),
    .irdy_n_i    (irdy_n),
    .gnt_n_o     (gnt_n),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid),
    .count_o     (count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // The queue holds waiting masters in arrival order; the owner stays at its front.
  int         m_q[$];
  logic [7:0] m_req_s;
  int         m_phase;   // 0 no grant, 1 granted awaiting FRAME, 2 transaction running
  int         m_gclk;    // granted clocks elapsed including the current one
  logic       m_valid;
  int         m_idx;

  function automatic bit m_member(input int d);
    foreach (m_q[k]) if (m_q[k] == d) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_req_s = '0;
    m_phase = 0;
    m_gclk  = 0;
    m_valid = 1'b0;
    m_idx   = 0;
  endtask

  task automatic model_step();
    int arrive;
    bit do_pop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    arrive = -1;
    for (int d = 7; d >= 0; d--) if (m_req_s[d] && !m_member(d)) arrive = d;
    do_pop = 1'b0;
    case (m_phase)
      0: if (m_q.size() > 0) begin
           if (m_req_s[m_q[0]]) begin
             m_phase = 1; m_gclk = 1; m_valid = 1'b1; m_idx = m_q[0];
           end else do_pop = 1'b1;
         end
      1: if (!frame_n) m_phase = 2;
         else if (!m_req_s[m_q[0]] || m_gclk == TMO) do_pop = 1'b1;
         else m_gclk++;
      default: if (frame_n && irdy_n) do_pop = 1'b1;
    endcase
    if (do_pop) begin
      void'(m_q.pop_front());
      m_phase = 0;
      m_valid = 1'b0;
    end
    if (arrive >= 0) m_q.push_back(arrive);
    m_req_s = ~req_n;
  endtask

  task automatic check_all();
    logic [7:0] eg;
    eg = 8'hFF;
    if (m_valid) eg[m_idx] = 1'b0;
    check("gnt_n", {24'd0, gnt_n}, {24'd0, eg});
    check("gnt_valid", {31'd0, gnt_valid}, {31'd0, m_valid});
    check("count", {28'd0, count}, m_q.size());
    if (m_valid) check("gnt_idx", {29'd0, gnt_idx}, m_idx);
  endtask

  // One clock: inputs already set, model follows the edge, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_grant(output int got);
    int n;
    n = 0;
    while (!gnt_valid && n < 64) begin
      cycle();
      n++;
    end
    check("grant_wait", {31'd0, gnt_valid}, 1);
    got = gnt_idx;
  endtask

  task automatic finish_txn(input int dev);
    frame_n = 1'b0; irdy_n = 1'b0; req_n[dev] = 1'b1;
    cycle();
    frame_n = 1'b1;
    cycle();
    irdy_n = 1'b1;
    cycle();
    check("retire", {31'd0, gnt_valid}, 0);
  endtask

  initial begin
    int got;
    int e;
    int g;
    int ord1[3];
    int ord2[4];
    ord1 = '{1, 3, 6};
    ord2 = '{0, 2, 4, 6};

    rst_n = 1'b1; req_n = 8'hFF; frame_n = 1'b1; irdy_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt_n", {24'd0, gnt_n}, 32'hFF);
    check("rst_gnt_idx", {29'd0, gnt_idx}, 0);
    check("rst_valid", {31'd0, gnt_valid}, 0);
    check("rst_count", {28'd0, count}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Quiet bus.
    for (int i = 0; i < 10; i++) cycle();

    // Single requester latency.
    req_n[5] = 1'b0;
    e = 0;
    do begin
      cycle();
      e++;
    end while (!gnt_valid && e < 10);
    check("lat5", e, 3);
    check("gnt5", {24'd0, gnt_n}, 32'hDF);
    check("idx5", {29'd0, gnt_idx}, 5);
    finish_txn(5);

    // Simultaneous arrivals are served lowest index first.
    req_n[6] = 1'b0; req_n[1] = 1'b0; req_n[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_grant(got);
      check("order_136", got, ord1[k]);
      finish_txn(got);
    end

    // Timeout and re-queue at the tail.
    req_n[2] = 1'b0;
    wait_grant(got);
    check("tmo_dev", got, 2);
    req_n[4] = 1'b0;
    g = 1;
    while (gnt_valid && g < 40) begin
      cycle();
      if (gnt_valid) g++;
    end
    check("tmo_clocks", g, 16);
    check("tmo_gnt_n", {24'd0, gnt_n}, 32'hFF);
    wait_grant(got);
    check("after_tmo_4", got, 4);
    finish_txn(got);
    wait_grant(got);
    check("requeued_2", got, 2);
    finish_txn(got);

    // Stale entry skip.
    req_n[0] = 1'b0;
    cycle();
    req_n[7] = 1'b0;
    wait_grant(got);
    check("dev0", got, 0);
    check("cnt07", {28'd0, count}, 2);
    req_n[7] = 1'b1;
    finish_txn(got);
    check("cnt_stale", {28'd0, count}, 1);
    cycle();
    check("skip_cnt", {28'd0, count}, 0);
    check("skip_no7", {31'd0, gnt_valid}, 0);

    // Reset pulse while busy with four entries queued.
    req_n = 8'hAA;
    wait_grant(got);
    check("busy_dev0", got, 0);
    frame_n = 1'b0; irdy_n = 1'b0;
    cycle();
    cycle();
    check("cnt4", {28'd0, count}, 4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_gnt_n", {24'd0, gnt_n}, 32'hFF);
    check("arst_count", {28'd0, count}, 0);
    check("arst_valid", {31'd0, gnt_valid}, 0);
    frame_n = 1'b1; irdy_n = 1'b1;
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(got);
      check("post_rst_order", got, ord2[k]);
      finish_txn(got);
    end

    // Random traffic against the model.
    req_n = 8'hFF;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        int b;
        b = $urandom_range(0, 7);
        req_n[b] = ~req_n[b];
      end
      frame_n = ($urandom_range(0, 3) != 0);
      irdy_n  = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_arbiter_req_fifo

`default_nettype wire

// File: doc/arbiter_req_fifo.md
# arbiter_req_fifo

First-in-first-out request queue and grant sequencer for the PCI arbiter in FIFO mode. Samples the eight active-low device request lines, queues each newly asserted requester's 3-bit index in arrival order, and drives an active-low one-hot grant to the head of the queue. It tracks bus ownership through FRAME_N/IRDY_N and retires the head when the owner's transaction ends, it withdraws its request, or it times out.

## Interface
- N_DEV, 8, number of bus masters; queue depth equals N_DEV.
- IDX_W, 3, index width, log2(N_DEV).
- TIMEOUT, 16, clocks a granted master has to assert FRAME_N before the grant is revoked.

- CLK  in  1  bus clock, all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- REQ_N  in  8  active-low request, bit i = device i.
- FRAME_N  in  1  PCI FRAME#, active-low.
- IRDY_N  in  1  PCI IRDY#, active-low.
- GNT_N  out  8  active-low one-hot grant; 8'hFF = no grant.
- GNT_IDX  out  3  index of the granted master; valid only while GNT_VALID = 1.
- GNT_VALID  out  1  a grant is asserted.
- COUNT  out  4  queued entries, 0..8.

## Operation
- Input stage: req_s <= ~REQ_N every edge. All decisions use req_s, never REQ_N directly.
- queued mask (8 bits): bit i is set while index i is in the queue or is the current owner.
- Arrivals: new = req_s & ~queued. At most one push per cycle, lowest set index first; the others wait for later cycles. A push sets queued[i]. Overflow is impossible because each index appears at most once.
- FSM states: IDLE, GRANT, BUSY.
  - IDLE, queue empty: stay. GNT_N = FF.
  - IDLE, head h with req_s[h] = 0: pop h, clear queued[h], no grant (stale-entry skip, 1 cycle).
  - IDLE, head h with req_s[h] = 1: go to GRANT, GNT_N[h] = 0, load timeout counter.
  - GRANT, FRAME_N sampled low: go to BUSY, grant held.
  - GRANT, req_s[h] = 0: pop, clear queued[h], GNT_N = FF, go to IDLE.
  - GRANT, counter reaches TIMEOUT: same as the withdraw case.
  - BUSY, FRAME_N = 1 and IRDY_N = 1 (bus idle): pop, clear queued[h], GNT_N = FF, go to IDLE.
- A retired owner still requesting reappears in new on the next cycle. It is re-queued at the tail, which gives round-robin fairness.
- A push and a pop in the same cycle are both performed; COUNT is unchanged.
- GNT_IDX = head index; GNT_N = ~(1 << GNT_IDX) when GNT_VALID, else 8'hFF.

## Timing
- Reset values: GNT_N = 8'hFF, GNT_IDX = 0, GNT_VALID = 0, COUNT = 0, state IDLE, queued = 0, read and write pointers = 0. Reset takes effect immediately, with no clock needed.
- Asserting reset mid-transaction drops the grant asynchronously. After release the queue rebuilds from the live REQ_N.
- All outputs are registered.
- Latency with an empty queue: REQ_N low before edge 1 → req_s at edge 1 → push at edge 2 → GNT_N low after edge 3.
- Grant deassertion happens one edge after the retire condition is sampled.
- There is always at least one idle clock with GNT_N = FF between two grants (no back-to-back GNT handover).
- Timeout counter starts at 0 on GRANT entry and increments every GRANT cycle. Revocation happens on the edge where the counter equals TIMEOUT-1, i.e. after exactly TIMEOUT granted clocks.
- Pointers are IDX_W bits and wrap modulo 8. COUNT is IDX_W+1 bits.

## Structure
- Shared package arb_pkg: N_DEV, IDX_W, TIMEOUT default, state enum {IDLE, GRANT, BUSY}.
- One sub-module, idx_queue: an 8×3 circular buffer with push, pop, head and count. Pop on empty and push on full are ignored; the parent guarantees neither occurs.
- Priority pick and grant decode stay in the parent.

## Test plan
- Reset, then REQ_N = FF for 10 clocks → GNT_N = FF, COUNT = 0 throughout.
- REQ_N[5] low → GNT_N = 8'hDF, GNT_IDX = 5, exactly 3 edges after the first sampling edge.
- REQ_N[6], [1] and [3] go low in the same cycle, and each master runs one FRAME transaction → grants in order 1, 3, 6, with one idle clock between each.
- Device 2 is granted and never asserts FRAME_N → GNT_N returns to FF after 16 granted clocks. With REQ_N[2] still low, device 2 is re-queued behind waiting device 4.
- Device 7 is queued behind device 0 and releases REQ_N before its turn → entry is skipped in 1 cycle, device 7 never sees a grant, COUNT decrements.
- RST_N pulsed low while in BUSY with 4 entries queued → GNT_N = FF and COUNT = 0 immediately. After release, masters still holding REQ_N low are re-queued in lowest-index-first order.
